// File: rtl/ram_io_responder_pkg.sv
// Shared definitions for the RAM/IO responder slice.
// Contents: byte type, IO window addresses, IO region decode value,
// read-source tag for the read pipeline, and the region decode helper.
package ram_io_responder_pkg;

  localparam int BYTE_W = 8;
  typedef logic [BYTE_W-1:0] byte_t;

  // IO window lives where address bits [17:16] are both set.
  localparam logic [1:0]  IO_REGION    = 2'b11;
  localparam logic [17:0] IO_DATA_ADDR = 18'h30000;
  localparam logic [17:0] IO_STAT_ADDR = 18'h30004;
  localparam logic [17:0] IO_END_ADDR  = 18'h30008;

  // Where the byte for a sampled read comes from.
  typedef enum logic {
    SRC_RAM = 1'b0,
    SRC_IO  = 1'b1
  } rd_src_e;

  function automatic logic is_io_region(input logic [1:0] region_bits);
    return region_bits == IO_REGION;
  endfunction

endpackage

// File: rtl/ram_io_responder_fifo.sv
// byte_fifo: synchronous byte FIFO used for both the TX and RX paths.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   push, din  write request and byte; accepted when not full, or when full
//              and a pop happens in the same cycle
//   pop        read request; ignored when empty
//   head       byte at the read pointer, 0 while empty
//   full, empty, count  occupancy status (count is log2(DEPTH)+1 bits)
module byte_fifo
  import ram_io_responder_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  byte_t                    din,
  input  logic                     pop,
  output byte_t                    head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  byte_t            mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  // A pop frees a slot this cycle, so a push into a full FIFO still lands.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage arrays carry no reset; occupancy is tracked by the
  // pointers and count, and an unreset array maps onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ram_io_responder.sv
// ram_io_responder: responder end of the byte-serial memory bus.
// Holds the byte-wide main RAM plus a memory-mapped IO window
// (IO_DATA / IO_STAT / IO_END) backed by a TX byte FIFO and, when the
// RAM_IO_RX_EN macro is defined, an RX byte FIFO.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en_in               access enable (gates RAM write, FIFO push/pop, output update)
//   mem_wr_in           1 = write, 0 = read
//   mem_addr_in         byte address; [17:16]==2'b11 selects the IO window
//   mem_data_in         write byte
//   mem_data_out        read byte, valid one cycle after the access is sampled
//   tx_valid_out/tx_data_out/tx_ready_in   TX FIFO drain handshake
//   rx_valid_in/rx_data_in/rx_ready_out    RX FIFO fill handshake
//   io_buffer_full_out  TX occupancy >= TX_DEPTH-1
//   tx_overflow_out     sticky: a TX push was dropped
//   sim_end_out         one-cycle pulse after a write to IO_END
module ram_io_responder
  import ram_io_responder_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_DEPTH       = 8,
  parameter int RX_DEPTH       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_in,
  input  logic        mem_wr_in,
  input  logic [31:0] mem_addr_in,
  input  logic [7:0]  mem_data_in,
  output logic [7:0]  mem_data_out,
  output logic        tx_valid_out,
  output logic [7:0]  tx_data_out,
  input  logic        tx_ready_in,
  input  logic        rx_valid_in,
  input  logic [7:0]  rx_data_in,
  output logic        rx_ready_out,
  output logic        io_buffer_full_out,
  output logic        tx_overflow_out,
  output logic        sim_end_out
);

  localparam int TX_CNT_W = $clog2(TX_DEPTH) + 1;
  localparam logic [TX_CNT_W-1:0] TX_HIGH_WATER = TX_CNT_W'(TX_DEPTH - 1);

  // ---------------- access decode ----------------
  logic        acc;
  logic        is_io;
  logic [17:0] io_addr;
  logic        io_data_hit, io_stat_hit, io_end_hit;
  logic        ram_we, tx_push, tx_pop, io_data_rd, rx_pop, fresh;

  assign acc         = en_in && !rst;   // reset-cycle accesses are discarded
  assign io_addr     = mem_addr_in[17:0];
  assign is_io       = is_io_region(mem_addr_in[17:16]);
  assign io_data_hit = is_io && (io_addr == IO_DATA_ADDR);
  assign io_stat_hit = is_io && (io_addr == IO_STAT_ADDR);
  assign io_end_hit  = is_io && (io_addr == IO_END_ADDR);

  assign ram_we      = acc && mem_wr_in && !is_io;
  assign tx_push     = acc && mem_wr_in && io_data_hit;
  assign io_data_rd  = acc && !mem_wr_in && io_data_hit;

  // A master idling on IO_DATA must consume exactly one RX byte.
  logic last_data_rd;
  assign fresh  = !last_data_rd;
  assign rx_pop = io_data_rd && fresh;

  // ---------------- TX FIFO ----------------
  byte_t                tx_head;
  logic                 tx_full, tx_empty;
  logic [TX_CNT_W-1:0]  tx_count;

  assign tx_valid_out       = !tx_empty;
  assign tx_data_out        = tx_head;
  assign tx_pop             = tx_valid_out && tx_ready_in;
  assign io_buffer_full_out = (tx_count >= TX_HIGH_WATER);

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .din   (mem_data_in),
    .pop   (tx_pop),
    .head  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  // ---------------- RX FIFO (optional) ----------------
  byte_t rx_head;
  logic  rx_nonempty;
  logic  unused_bits;

`ifdef RAM_IO_RX_EN
  localparam int RX_CNT_W = $clog2(RX_DEPTH) + 1;
  logic                rx_full, rx_empty;
  logic [RX_CNT_W-1:0] rx_count;

  assign rx_ready_out = !rx_full;
  assign rx_nonempty  = !rx_empty;

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_valid_in && rx_ready_out),
    .din   (rx_data_in),
    .pop   (rx_pop),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  assign unused_bits = ^{mem_addr_in[31:18], rx_count};
`else
  assign rx_ready_out = 1'b0;
  assign rx_nonempty  = 1'b0;
  assign rx_head      = '0;
  assign unused_bits  = ^{mem_addr_in[31:18], rx_valid_in, rx_data_in, rx_pop,
                          RX_DEPTH[0]};
`endif

  // ---------------- RAM ----------------
  byte_t ram [2**RAM_ADDR_WIDTH];
  byte_t ram_q;

  // Read captures the pre-write byte, so read-during-write returns old data.
  always_ff @(posedge clk) begin
    if (ram_we) ram[mem_addr_in[RAM_ADDR_WIDTH-1:0]] <= mem_data_in;
    ram_q <= ram[mem_addr_in[RAM_ADDR_WIDTH-1:0]];
  end

  // ---------------- read pipeline ----------------
  logic    rd_valid;
  rd_src_e rd_src;
  byte_t   io_q;
  byte_t   io_rd_byte;

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned and infers a latch.
  always_comb begin
    io_rd_byte = '0;
    if (io_data_hit) begin
      // A repeated read of a held IO_DATA address returns the same byte.
      io_rd_byte = fresh ? rx_head : io_q;
    end else if (io_stat_hit) begin
      io_rd_byte = {6'b0, rx_nonempty, tx_full};
    end
  end

  // Stage 1: sample the access; stage 2: present the byte one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid     <= 1'b0;
      rd_src       <= SRC_RAM;
      io_q         <= '0;
      last_data_rd <= 1'b0;
    end else if (en_in) begin
      rd_valid     <= !mem_wr_in;
      rd_src       <= is_io ? SRC_IO : SRC_RAM;
      if (!mem_wr_in && is_io) io_q <= io_rd_byte;
      last_data_rd <= io_data_rd;
    end else begin
      rd_valid     <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_data_out <= '0;
    end else if (rd_valid) begin
      mem_data_out <= (rd_src == SRC_RAM) ? ram_q : io_q;
    end
  end

  // ---------------- status flags ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_overflow_out <= 1'b0;
      sim_end_out     <= 1'b0;
    end else begin
      if (tx_push && tx_full && !tx_pop) tx_overflow_out <= 1'b1;
      sim_end_out <= acc && mem_wr_in && io_end_hit;
    end
  end

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed self-checking bench for ram_io_responder.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_ram_io_responder;

  localparam logic [31:0] IO_DATA = 32'h0003_0000;
  localparam logic [31:0] IO_STAT = 32'h0003_0004;
  localparam logic [31:0] IO_END  = 32'h0003_0008;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_in;
  logic        mem_wr_in;
  logic [31:0] mem_addr_in;
  logic [7:0]  mem_data_in;
  logic [7:0]  mem_data_out;
  logic        tx_valid_out;
  logic [7:0]  tx_data_out;
  logic        tx_ready_in;
  logic        rx_valid_in;
  logic [7:0]  rx_data_in;
  logic        rx_ready_out;
  logic        io_buffer_full_out;
  logic        tx_overflow_out;
  logic        sim_end_out;

  int checks   = 0;
  int failures = 0;

  ram_io_responder dut (
    .clk                (clk),
    .rst                (rst),
    .en_in              (en_in),
    .mem_wr_in          (mem_wr_in),
    .mem_addr_in        (mem_addr_in),
    .mem_data_in        (mem_data_in),
    .mem_data_out       (mem_data_out),
    .tx_valid_out       (tx_valid_out),
    .tx_data_out        (tx_data_out),
    .tx_ready_in        (tx_ready_in),
    .rx_valid_in        (rx_valid_in),
    .rx_data_in         (rx_data_in),
    .rx_ready_out       (rx_ready_out),
    .io_buffer_full_out (io_buffer_full_out),
    .tx_overflow_out    (tx_overflow_out),
    .sim_end_out        (sim_end_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_acc(input logic [31:0] addr, input logic [7:0] data);
    en_in = 1'b1; mem_wr_in = 1'b1; mem_addr_in = addr; mem_data_in = data;
    step();
    en_in = 1'b0; mem_wr_in = 1'b0;
  endtask

  // Sample a read, then one idle edge: mem_data_out then holds the byte.
  task automatic read_acc(input logic [31:0] addr);
    en_in = 1'b1; mem_wr_in = 1'b0; mem_addr_in = addr;
    step();
    en_in = 1'b0;
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dout"},  mem_data_out, 8'h00);
    check({tag, "_txv"},   tx_valid_out, 1'b0);
    check({tag, "_txd"},   tx_data_out, 8'h00);
`ifdef RAM_IO_RX_EN
    check({tag, "_rxr"},   rx_ready_out, 1'b1);
`else
    check({tag, "_rxr"},   rx_ready_out, 1'b0);
`endif
    check({tag, "_full"},  io_buffer_full_out, 1'b0);
    check({tag, "_ovf"},   tx_overflow_out, 1'b0);
    check({tag, "_end"},   sim_end_out, 1'b0);
  endtask

  initial begin
    rst = 1'b1; en_in = 1'b0; mem_wr_in = 1'b0; mem_addr_in = '0; mem_data_in = '0;
    tx_ready_in = 1'b0; rx_valid_in = 1'b0; rx_data_in = '0;
    step(); step();
    rst = 1'b0;
    check_reset_outputs("reset");

    // ---- RAM write / read latency ----
    write_acc(32'h10, 8'hA5);
    en_in = 1'b1; mem_wr_in = 1'b0; mem_addr_in = 32'h10;
    step();
    en_in = 1'b0;
    check("rd_not_early", mem_data_out, 8'h00);
    step();
    check("rd_a5", mem_data_out, 8'hA5);

    // ---- back-to-back streaming reads ----
    write_acc(32'h11, 8'hB1);
    write_acc(32'h12, 8'hB2);
    write_acc(32'h13, 8'hB3);
    en_in = 1'b1; mem_wr_in = 1'b0;
    mem_addr_in = 32'h10; step();
    mem_addr_in = 32'h11; step(); check("stream0", mem_data_out, 8'hA5);
    mem_addr_in = 32'h12; step(); check("stream1", mem_data_out, 8'hB1);
    mem_addr_in = 32'h13; step(); check("stream2", mem_data_out, 8'hB2);
    en_in = 1'b0;         step(); check("stream3", mem_data_out, 8'hB3);
    step();                       check("hold_en_low", mem_data_out, 8'hB3);

    // ---- TX fill with consumer stalled ----
    tx_ready_in = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      write_acc(IO_DATA, 8'(i));
      check($sformatf("txfull_%0d", i), io_buffer_full_out, (i >= 7));
      check($sformatf("txovf_%0d", i),  tx_overflow_out,    (i >= 9));
    end
    tx_ready_in = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("drain_v%0d", k), tx_valid_out, 1'b1);
      check($sformatf("drain_d%0d", k), tx_data_out, 8'(k));
      step();
    end
    tx_ready_in = 1'b0;
    check("drain_empty", tx_valid_out, 1'b0);
    check("ovf_sticky", tx_overflow_out, 1'b1);

    // ---- full TX with simultaneous pop and push ----
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 8; i++) write_acc(IO_DATA, 8'h10 + 8'(i));
    check("full8_flag", io_buffer_full_out, 1'b1);
    read_acc(IO_STAT);
    check("stat_txfull", mem_data_out, 8'h01);
    tx_ready_in = 1'b1;
    write_acc(IO_DATA, 8'h18);
    tx_ready_in = 1'b0;
    check("pushpop_ovf", tx_overflow_out, 1'b0);
    check("pushpop_head", tx_data_out, 8'h11);
    check("pushpop_full", io_buffer_full_out, 1'b1);
    tx_ready_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("pp_d%0d", k), tx_data_out, 8'h11 + 8'(k));
      step();
    end
    tx_ready_in = 1'b0;
    check("pp_empty", tx_valid_out, 1'b0);

    // ---- simulation end pulse ----
    check("end_idle", sim_end_out, 1'b0);
    write_acc(IO_END, 8'h00);
    check("end_pulse", sim_end_out, 1'b1);
    step();
    check("end_once", sim_end_out, 1'b0);

    // ---- reset during a RAM write ----
    write_acc(32'h20, 8'h33);
    write_acc(IO_DATA, 8'h99);
    check("pre_rst_txv", tx_valid_out, 1'b1);
    rst = 1'b1; en_in = 1'b1; mem_wr_in = 1'b1; mem_addr_in = 32'h20; mem_data_in = 8'h77;
    step();
    rst = 1'b0; en_in = 1'b0; mem_wr_in = 1'b0;
    check_reset_outputs("midrst");
    read_acc(32'h20);
    check("rst_no_write", mem_data_out, 8'h33);

    // ---- RX path ----
`ifdef RAM_IO_RX_EN
    rx_valid_in = 1'b1; rx_data_in = 8'h41; step();
    rx_data_in = 8'h42; step();
    rx_valid_in = 1'b0;
    check("rx_ready", rx_ready_out, 1'b1);
    read_acc(IO_STAT);
    check("stat_rx", mem_data_out, 8'h02);
    en_in = 1'b1; mem_wr_in = 1'b0; mem_addr_in = IO_DATA;
    step();
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("held_%0d", c), mem_data_out, 8'h41);
    end
    mem_addr_in = 32'h10; step(); check("held_last", mem_data_out, 8'h41);
    mem_addr_in = IO_DATA; step(); check("rx_ram_between", mem_data_out, 8'hA5);
    en_in = 1'b0; step(); check("rx_second", mem_data_out, 8'h42);
    read_acc(32'h10);
    read_acc(IO_DATA);
    check("rx_drained", mem_data_out, 8'h00);
`else
    rx_valid_in = 1'b1; rx_data_in = 8'h41; step(); step();
    check("norx_ready", rx_ready_out, 1'b0);
    en_in = 1'b1; mem_wr_in = 1'b0; mem_addr_in = 32'h10; step();
    mem_addr_in = IO_DATA; step(); check("norx_ram", mem_data_out, 8'hA5);
    en_in = 1'b0; step(); check("norx_data", mem_data_out, 8'h00);
    read_acc(32'h10);
    read_acc(IO_STAT);
    check("norx_stat", mem_data_out, 8'h00);
    check("norx_ready2", rx_ready_out, 1'b0);
    rx_valid_in = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
